// File: rtl/bf_pkg.sv
// bf_pkg: opcodes, fetch states and decode helper shared by the fetch unit and its scanner
package bf_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_HALT  = 4'h1,
        OP_INC   = 4'h2,
        OP_DEC   = 4'h3,
        OP_RIGHT = 4'h4,
        OP_LEFT  = 4'h5,
        OP_JZ    = 4'h6,
        OP_JNZ   = 4'h7,
        OP_OUT   = 4'h8,
        OP_IN    = 4'h9
    } bf_op_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, SCAN_FWD, SCAN_BACK, HALTED, ERROR
    } fetch_state_t;

    function automatic logic is_exec(input logic [3:0] op);
        return op inside {OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN};
    endfunction
endpackage

// File: rtl/bf_bracket_scanner.sv
// bf_bracket_scanner: nesting-depth tracker used while skipping over a bracketed block in either direction
module bf_bracket_scanner
    import bf_pkg::*;
#(
    parameter int DEPTH_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic       dir,
    input  logic [3:0] op,
    output logic       match,
    output logic       overflow
);
    logic [DEPTH_W-1:0] depth;
    logic opener, closer;
    // dir=0 walks forward (nests on '['), dir=1 walks backward (nests on ']')
    assign opener   = op == (dir ? OP_JNZ : OP_JZ);
    assign closer   = op == (dir ? OP_JZ : OP_JNZ);
    assign match    = step && closer && depth == DEPTH_W'(1);
    assign overflow = step && opener && &depth;
    always_ff @(posedge clk)
        if (rst) depth <= '0;
        else if (start) depth <= DEPTH_W'(1);
        else if (step && opener && !overflow) depth <= depth + DEPTH_W'(1);
        else if (step && closer) depth <= depth - DEPTH_W'(1);
endmodule

// File: rtl/bf_fetch_unit.sv
// bf_fetch_unit: walks the program ROM, resolves brackets by scanning and issues the
// remaining executable opcodes to the execution unit over valid/ready.
module bf_fetch_unit
    import bf_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSN_W  = 4,
    parameter int DEPTH_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    output logic [ADDR_W-1:0] Address,
    input  logic [INSN_W-1:0] Data,
    output logic [INSN_W-1:0] Insn,
    output logic              InsnValid,
    input  logic              InsnReady,
    input  logic              DataZero,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);
    fetch_state_t state, state_n;
    logic [ADDR_W-1:0] ip, ip_n, ip_inc, ip_dec;
    logic [INSN_W-1:0] insn_n;
    logic [3:0] op;
    logic ip_first, ip_last;
    logic scan_start, scan_step, scan_dir, scan_match, scan_overflow;

    assign op        = 4'(Data);
    assign ip_inc    = ip + ADDR_W'(1);
    assign ip_dec    = ip - ADDR_W'(1);
    assign ip_first  = ip == '0;
    assign ip_last   = &ip;
    assign scan_step = state inside {SCAN_FWD, SCAN_BACK};
    assign scan_dir  = state == SCAN_BACK;

    assign Address   = ip;
    assign InsnValid = state == ISSUE;
    assign Busy      = state inside {FETCH, ISSUE, SCAN_FWD, SCAN_BACK};
    assign Halted    = state == HALTED;
    assign Error     = state == ERROR;

    bf_bracket_scanner #(.DEPTH_W(DEPTH_W)) scanner (
        .clk      (Clk),
        .rst      (Rst),
        .start    (scan_start),
        .step     (scan_step),
        .dir      (scan_dir),
        .op       (op),
        .match    (scan_match),
        .overflow (scan_overflow)
    );

    always_comb begin
        state_n    = state;
        ip_n       = ip;
        insn_n     = Insn;
        scan_start = 1'b0;
        case (state)
            IDLE:
                if (Run) begin
                    ip_n    = '0;
                    state_n = FETCH;
                end
            FETCH:
                if (op == OP_HALT) state_n = HALTED;
                else if (is_exec(op)) begin
                    insn_n  = Data;
                    state_n = ISSUE;
                end else if (op == OP_JZ && DataZero) begin
                    // a skip that would have to start past the last address can never find its ']'
                    scan_start = 1'b1;
                    state_n    = ip_last ? ERROR : SCAN_FWD;
                    ip_n       = ip_last ? ip : ip_inc;
                end else if (op == OP_JNZ && !DataZero) begin
                    scan_start = 1'b1;
                    state_n    = ip_first ? ERROR : SCAN_BACK;
                    ip_n       = ip_first ? ip : ip_dec;
                end else ip_n = ip_inc;
            ISSUE:
                if (InsnReady) begin
                    ip_n    = ip_inc;
                    state_n = FETCH;
                end
            SCAN_FWD, SCAN_BACK:
                if (scan_overflow) state_n = ERROR;
                else if (scan_match) begin
                    ip_n    = ip_inc;
                    state_n = FETCH;
                end else if (state == SCAN_FWD ? ip_last : ip_first) state_n = ERROR;
                else ip_n = state == SCAN_FWD ? ip_inc : ip_dec;
            default:
                if (!Run) begin
                    ip_n    = '0;
                    state_n = IDLE;
                end
        endcase
    end

    always_ff @(posedge Clk)
        if (Rst) begin
            state <= IDLE;
            ip    <= '0;
            Insn  <= '0;
        end else begin
            state <= state_n;
            ip    <= ip_n;
            Insn  <= insn_n;
        end
endmodule

// File: tb/tb_bf_fetch_unit.sv
// tb_bf_fetch_unit: directed and random BF programs checked against an interpreter-level model
module tb_bf_fetch_unit;
    localparam int DW    = 2;
    localparam int MAXD  = (1 << DW) - 1;
    localparam int LIMIT = 8000;

    logic clk = 1'b0, rst = 1'b1, run = 1'b0, insn_ready = 1'b0;
    logic [7:0] address;
    logic [3:0] data, insn;
    logic insn_valid, data_zero, busy, halted, error;
    logic [3:0] rom [256];
    logic [7:0] cells [256];
    logic [7:0] ptr = 8'd0;
    logic [3:0] pool [14] = '{2, 2, 2, 3, 3, 4, 5, 6, 6, 7, 7, 8, 9, 0};
    logic [7:0] back_seq [7] = '{8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h0A};
    logic [3:0] got_ops [$], exp_ops [$];
    logic [7:0] trace [$];
    int passed = 0, total = 0, stalls, busy_cyc, exp_cyc, idx;
    bit exp_halt, exp_err, model_ok;
    logic [7:0] exp_addr;

    assign data      = rom[address];
    assign data_zero = cells[ptr] == 8'd0;

    bf_fetch_unit #(.ADDR_W(8), .INSN_W(4), .DEPTH_W(DW)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Run       (run),
        .Address   (address),
        .Data      (data),
        .Insn      (insn),
        .InsnValid (insn_valid),
        .InsnReady (insn_ready),
        .DataZero  (data_zero),
        .Busy      (busy),
        .Halted    (halted),
        .Error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] enc(input byte c);
        case (c)
            "H": return 4'h1;
            "+": return 4'h2;
            "-": return 4'h3;
            ">": return 4'h4;
            "<": return 4'h5;
            "[": return 4'h6;
            "]": return 4'h7;
            ".": return 4'h8;
            ",": return 4'h9;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [7:0] new_cell(input logic [3:0] op, input logic [7:0] v);
        return op == 4'h2 ? v + 8'd1 : op == 4'h3 ? v - 8'd1 : op == 4'h9 ? 8'h03 : v;
    endfunction

    function automatic logic [7:0] new_ptr(input logic [3:0] op, input logic [7:0] p);
        return op == 4'h4 ? p + 8'd1 : op == 4'h5 ? p - 8'd1 : p;
    endfunction

    task automatic load(input string s);
        foreach (rom[i]) rom[i] = 4'h0;
        for (int i = 0; i < s.len(); i++) rom[i] = enc(s[i]);
    endtask

    task automatic clear_env();
        foreach (cells[i]) cells[i] = 8'd0;
        ptr = 8'd0;
    endtask

    // Reference interpreter: what a BF machine does with this ROM, plus the fetch unit's cycle cost
    task automatic model();
        logic [7:0] mc [256];
        logic [7:0] p, mp;
        logic [3:0] opn, cls;
        int d, a, s, steps;
        bit done;
        p = 0; mp = 0; steps = 0; done = 0;
        exp_ops.delete(); exp_cyc = 0; exp_halt = 0; exp_err = 0; exp_addr = 0; model_ok = 1;
        foreach (mc[i]) mc[i] = 8'd0;
        while (!done) begin
            steps++;
            if (steps > 600) begin
                model_ok = 0;
                break;
            end
            exp_cyc++;
            if (rom[p] == 4'h1) begin
                exp_halt = 1; exp_addr = p; done = 1;
            end else if (rom[p] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9}) begin
                exp_ops.push_back(rom[p]);
                exp_cyc++;
                mc[mp] = new_cell(rom[p], mc[mp]);
                mp = new_ptr(rom[p], mp);
                p = p + 8'd1;
            end else if ((rom[p] == 4'h6 && mc[mp] == 0) || (rom[p] == 4'h7 && mc[mp] != 0)) begin
                s = rom[p] == 4'h6 ? 1 : -1;
                opn = rom[p];
                cls = rom[p] == 4'h6 ? 4'h7 : 4'h6;
                d = 1;
                a = int'(p);
                while (d > 0 && !done) begin
                    if (a + s < 0 || a + s > 255) begin
                        exp_err = 1; exp_addr = 8'(a); done = 1;
                    end else begin
                        a += s;
                        exp_cyc++;
                        if (rom[a] == opn) begin
                            if (d == MAXD) begin
                                exp_err = 1; exp_addr = 8'(a); done = 1;
                            end else d++;
                        end else if (rom[a] == cls) d--;
                    end
                end
                p = 8'(a + 1);
            end else p = p + 8'd1;
        end
    endtask

    task automatic execute(input int stall_pct);
        int n;
        n = 0;
        got_ops.delete(); trace.delete(); stalls = 0; busy_cyc = 0;
        clear_env();
        @(negedge clk) run = 1'b1;
        do begin
            @(negedge clk);
            insn_ready = $urandom_range(99) >= stall_pct;
            if (busy) begin
                busy_cyc++;
                trace.push_back(address);
            end
            if (insn_valid && !insn_ready) stalls++;
            if (insn_valid && insn_ready) begin
                got_ops.push_back(insn);
                cells[ptr] = new_cell(insn, cells[ptr]);
                ptr = new_ptr(insn, ptr);
            end
            n++;
        end while (!halted && !error && n < LIMIT);
        check("terminate", n < LIMIT, 1'b1);
    endtask

    task automatic compare(input string tag);
        check({tag, " halted"}, halted, exp_halt);
        check({tag, " error"}, error, exp_err);
        check({tag, " address"}, address, exp_addr);
        check({tag, " busy/valid"}, {busy, insn_valid}, 2'b00);
        check({tag, " issued"}, got_ops.size(), exp_ops.size());
        for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++)
            check({tag, " op"}, got_ops[i], exp_ops[i]);
        check({tag, " cycles"}, busy_cyc, exp_cyc + stalls);
    endtask

    task automatic stop_run();
        @(negedge clk) run = 1'b0;
        @(negedge clk);
        check("idle", {busy, halted, error, address}, 0);
    endtask

    initial begin
        load("H");
        clear_env();
        repeat (2) @(negedge clk);
        check("reset", {address, insn, insn_valid, busy, halted, error}, 0);
        rst = 1'b0;

        load("+++++++++[-+-nn]H");
        model();
        execute(0);
        compare("loop");
        check("loop handshakes", got_ops.size(), 36);
        check("loop halt addr", {halted, address}, {1'b1, 8'h10});
        idx = -1;
        foreach (trace[i]) if (idx < 0 && trace[i] == 8'h0F) idx = i;
        check("loop trace len", trace.size() > idx + 7, 1'b1);
        for (int k = 0; k < 7; k++) check("scan back", trace[idx + 1 + k], back_seq[k]);
        stop_run();

        model();
        execute(40);
        compare("loop stall");
        stop_run();

        load("[[+]]H");
        model();
        execute(0);
        compare("skip");
        check("skip result", {got_ops.size() == 0, halted, address}, {2'b11, 8'h05});
        stop_run();

        load("+]H");
        model();
        execute(0);
        compare("unmatched");
        check("unmatched flags", {error, busy, insn_valid}, 3'b100);
        stop_run();

        load("+nH");
        insn_ready = 1'b0;
        @(negedge clk) run = 1'b1;
        repeat (2) @(negedge clk);
        repeat (5) begin
            check("hold", {insn, insn_valid, address}, {4'h2, 1'b1, 8'h00});
            @(negedge clk);
        end
        insn_ready = 1'b1;
        @(negedge clk);
        check("after handshake", {insn_valid, address}, {1'b0, 8'h01});
        for (int k = 0; k < 10 && !halted; k++) @(negedge clk);
        check("hold halt", {halted, address}, {1'b1, 8'h02});
        stop_run();

        load("[[[[]]]]H");
        model();
        execute(0);
        compare("overflow");
        check("overflow at", {error, address}, {1'b1, 8'h03});
        stop_run();

        load("[nnnnnnnnnnnn]H");
        clear_env();
        @(negedge clk) run = 1'b1;
        repeat (4) @(negedge clk);
        check("scan busy", {busy, address}, {1'b1, 8'h03});
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check("rst outputs", {address, insn, insn_valid, busy, halted, error}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst idle", {busy, address}, 0);

        for (int t = 0; t < 25; t++) begin
            int len;
            do begin
                foreach (rom[i]) rom[i] = 4'h0;
                len = $urandom_range(24, 6);
                for (int i = 0; i < len; i++) rom[i] = pool[$urandom_range(13)];
                rom[len] = 4'h1;
                model();
            end while (!model_ok);
            execute($urandom_range(50));
            compare("rand");
            stop_run();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
